// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO word packer:
//   DATA_WIDTH_DEF / PACK_DEF : default entry width and entries per output word
//   state_t                   : packer FSM states (FILL / FULL / FLUSH)
//   lane_cnt_t                : lane counter able to hold 0..PACK_DEF
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PACK_DEF       = 4;

  // FILL : accumulator still collecting entries (count < PACK)
  // FULL : accumulator complete, waiting for the output register
  // FLUSH: partial word requested, waiting for the in-flight entry to land
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef logic [$clog2(PACK_DEF+1)-1:0] lane_cnt_t;

endpackage

// File: rtl/packer_out_reg.sv
// -----------------------------------------------------------------------------
// packer_out_reg
// Output holding register of the word packer.
//
// Handshake: a word is transferred downstream on every rising edge where
// m_valid_o && m_ready_i. While m_valid_o && !m_ready_i, m_valid_o, m_data_o
// and m_keep_o hold stable. A new word may be loaded only when free_o is high
// (register empty, or its current word leaves on this edge), so back-to-back
// words are possible.
//
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   load_i        : load data_i/keep_i on this edge (only asserted when free_o)
//   data_i,keep_i : packed word and lane-valid mask to load
//   m_ready_i     : downstream ready
//   free_o        : register can accept a word on this edge
//   m_valid_o, m_data_o, m_keep_o : downstream word interface
// -----------------------------------------------------------------------------
module packer_out_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       load_i,
  input  logic [DATA_WIDTH*PACK-1:0] data_i,
  input  logic [PACK-1:0]            keep_i,
  input  logic                       m_ready_i,
  output logic                       free_o,
  output logic                       m_valid_o,
  output logic [DATA_WIDTH*PACK-1:0] m_data_o,
  output logic [PACK-1:0]            m_keep_o
);

  logic                       valid_q;
  logic [DATA_WIDTH*PACK-1:0] data_q;
  logic [PACK-1:0]            keep_q;

  assign free_o = !valid_q || m_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
    end else if (m_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_keep_o  = keep_q;

endmodule

// File: rtl/fifo_word_packer.sv
// -----------------------------------------------------------------------------
// fifo_word_packer
// Reads DATA_WIDTH entries from a first-word-fall-through-less FIFO (data valid
// one cycle after rd_en) and packs PACK of them into one OUT_WIDTH word.
// Lane 0 holds the first entry read; lanes fill upward.
//
// Optional feature (macro PACKER_FLUSH_EN): 'flush' emits a partial word with
// m_keep marking the filled lanes. Without the macro, flush is ignored.
//
// Ports:
//   rd_clk      : sole clock (FIFO read domain)
//   rst         : asynchronous active-high reset
//   fifo_empty  : FIFO empty flag
//   fifo_data   : FIFO read data, valid one cycle after an accepted fifo_rd_en
//   fifo_rd_en  : FIFO read request (combinational)
//   flush       : request emission of a partial word
//   m_valid/m_ready/m_data/m_keep : downstream word interface (valid/ready)
//   dbg_state_o : current FSM state
// -----------------------------------------------------------------------------
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK       = PACK_DEF
) (
  input  logic                       rd_clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  output logic                       fifo_rd_en,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH*PACK-1:0] m_data,
  output logic [PACK-1:0]            m_keep,
  output state_t                     dbg_state_o
);

  localparam int              OUT_WIDTH = DATA_WIDTH * PACK;
  localparam int              CW        = $clog2(PACK + 1);
  localparam logic [CW-1:0]   FULL_CNT  = CW'(PACK);

  logic [CW-1:0]        count_q, count_d;
  logic                 pending_q;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic                 flush_req_q, flush_req_d;
  state_t               state_q, state_d;

  logic                 out_free;
  logic                 full_xfer;
  logic                 flush_xfer;
  logic                 flush_done;
  logic                 load;
  logic                 room;
  logic [PACK-1:0]      keep_d;
  logic [OUT_WIDTH-1:0] word_d;

  // Reads in flight count against the capacity so the accumulator never
  // overflows: an issued read always has a lane waiting for it.
  assign room       = ({1'b0, count_q} + {{CW{1'b0}}, pending_q}) < {1'b0, FULL_CNT};
  assign fifo_rd_en = !fifo_empty && !flush_req_q && room && !rst;

  // When count == PACK, pending is necessarily 0 (room was exhausted).
  assign full_xfer = (count_q == FULL_CNT) && out_free;

`ifdef PACKER_FLUSH_EN
  // A flush waits for the in-flight entry to land, then either ships the
  // partial word or, with nothing accumulated, simply retires.
  assign flush_xfer  = flush_req_q && !pending_q && (count_q != '0) && out_free;
  assign flush_done  = flush_req_q && !pending_q && ((count_q == '0) || out_free);
  assign flush_req_d = flush || (flush_req_q && !flush_done);
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_xfer   = 1'b0;
  assign flush_done   = 1'b0;
  assign flush_req_d  = 1'b0;
`endif

  assign load = full_xfer || flush_xfer;

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q + CW'(pending_q);
    keep_d  = '0;
    word_d  = '0;
    for (int i = 0; i < PACK; i++) begin
      // Entry arriving this cycle lands in lane[count]
      if (pending_q && (count_q == CW'(i))) begin
        acc_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
      end
      // Lanes below count are filled; unfilled lanes are shipped as zero
      keep_d[i] = (CW'(i) < count_q);
      if (keep_d[i]) begin
        word_d[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (load) begin
      count_d = '0;
    end
    if (flush_req_d) begin
      state_d = FLUSH;
    end else if (count_d == FULL_CNT) begin
      state_d = FULL;
    end else begin
      state_d = FILL;
    end
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      pending_q   <= 1'b0;
      acc_q       <= '0;
      flush_req_q <= 1'b0;
      state_q     <= FILL;
    end else begin
      count_q     <= count_d;
      pending_q   <= fifo_rd_en;
      acc_q       <= acc_d;
      flush_req_q <= flush_req_d;
      state_q     <= state_d;
    end
  end

  assign dbg_state_o = state_q;

  packer_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK       (PACK)
  ) u_out_reg (
    .clk_i     (rd_clk),
    .rst_i     (rst),
    .load_i    (load),
    .data_i    (word_d),
    .keep_i    (keep_d),
    .m_ready_i (m_ready),
    .free_o    (out_free),
    .m_valid_o (m_valid),
    .m_data_o  (m_data),
    .m_keep_o  (m_keep)
  );

endmodule

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL be the width of one FIFO entry.
REQ-002 Parameter PACK, default 4, SHALL be the number of FIFO entries per output word; OUT_WIDTH = DATA_WIDTH*PACK.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 rd_clk  in  1  SHALL be the sole clock (FIFO read domain).
REQ-005 rst  in  1  SHALL be the asynchronous active-high reset.
REQ-006 fifo_empty  in  1  SHALL be the FIFO empty flag.
REQ-007 fifo_data  in  DATA_WIDTH  SHALL be the FIFO read data, valid one cycle after an accepted rd_en.
REQ-008 fifo_rd_en  out  1  SHALL be the FIFO read request.
REQ-009 flush  in  1  SHALL request emission of a partial word.
REQ-010 m_valid  out  1  SHALL flag a valid output word.
REQ-011 m_ready  in  1  SHALL flag downstream acceptance.
REQ-012 m_data  out  OUT_WIDTH  SHALL be the packed word.
REQ-013 m_keep  out  PACK  SHALL mark the valid lanes of m_data.

Function
REQ-014 fifo_rd_en SHALL equal !fifo_empty && !flush_req && (count+pending < PACK) && !rst, combinationally.
REQ-015 pending SHALL be set the cycle after fifo_rd_en=1 and cleared otherwise; a pending byte SHALL be written into lane[count], and count SHALL increment.
REQ-016 Lane 0 (bits DATA_WIDTH-1:0) SHALL hold the first byte read; lanes fill in ascending order.
REQ-017 States: FILL (count<PACK), FULL (count==PACK, waiting for the output register), FLUSH (flush_req set, waiting for pending==0).
REQ-018 FILL->FULL SHALL occur when count reaches PACK; FULL->FILL SHALL occur when the accumulator transfers to the output register.
REQ-019 Transfer SHALL occur when the accumulator is complete and (!m_valid || m_ready), loading m_data, setting m_keep to all ones, setting m_valid=1, and clearing count to 0, all in the same edge.
REQ-020 Latency: the last byte captured at edge N SHALL give m_valid=1 after edge N+1 when the output register is free.
REQ-021 m_valid, m_data and m_keep SHALL hold stable while m_valid && !m_ready.
REQ-022 m_valid SHALL clear after an edge with m_ready=1 and no new transfer.
REQ-023 Back-to-back output SHALL be possible: the accumulator refills while the output register is held.
REQ-024 fifo_empty rising with a read pending SHALL NOT drop the pending byte.
REQ-025 FIFO order SHALL be preserved with no duplicated or lost bytes under arbitrary m_ready and fifo_empty patterns.

Reset
REQ-026 While rst=1: m_valid=0, m_data=0, m_keep=0, fifo_rd_en=0, count=0, pending=0, flush_req=0, state FILL.
REQ-027 Reset mid-word SHALL discard the partial accumulator and any in-flight byte; the first byte read after reset SHALL land in lane 0.

Configuration
REQ-028 Macro PACKER_FLUSH_EN SHALL gate the flush feature.
REQ-029 With PACKER_FLUSH_EN: flush=1 SHALL set flush_req; when pending==0, a partial word SHALL transfer under REQ-019 with m_keep = (1<<count)-1; with count==0, flush_req SHALL clear and no word SHALL be emitted.
REQ-030 Without PACKER_FLUSH_EN: flush SHALL be ignored, flush_req SHALL be constant 0, and m_keep SHALL be all ones whenever m_valid=1.

Structure
REQ-031 Package fifo_pkg SHALL hold DATA_WIDTH and PACK defaults, the state enum (FILL/FULL/FLUSH) and the lane-count type.
REQ-032 The output register and its valid/ready hold logic SHALL be sub-module packer_out_reg; accumulation and the FSM stay in fifo_word_packer.

Verification
REQ-033 Bytes 0x11,0x22,0x33,0x44, m_ready=1 -> m_data=0x44332211, m_keep=4'hF, one m_valid pulse.
REQ-034 16 bytes continuous with m_ready=0 for 20 cycles -> first word held stable, fifo_rd_en=0 after 8 bytes in flight/held, 4 words in order after release.
REQ-035 fifo_empty toggling every cycle during 8 bytes -> 2 words, data intact, no extra fifo_rd_en while empty.
REQ-036 (PACKER_FLUSH_EN) 0xA1,0xB2 then flush -> m_data[15:0]=0xB2A1, m_keep=4'h3; flush with count=0 -> no m_valid.
REQ-037 rst asserted after 3 bytes, then 0x01..0x04 -> all outputs 0 during rst, next word 0x04030201.
REQ-038 Random m_ready (50%) with 1000 random bytes -> scoreboard match, m_data stable while stalled.
